// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and default widths.
// Pure declarations: no latency and no flow control.
package sdram_pkg;

    localparam int ADDR_W_DEF   = 13;
    localparam int MAX_BUSY_DEF = 64;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// State-indexed mux of the owning master's cmd/addr/bank onto the SDRAM pins.
// Latency: purely combinational. Backpressure: none, the state alone selects.
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  arb_state_t        state,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_bank,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_bank,
    output logic [3:0]        cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        bank
);

    always_comb begin
        cmd  = CMD_NOP;
        addr = '0;
        bank = 2'd0;
        case (state)
            ST_INIT: begin
                cmd  = init_cmd;
                addr = init_addr;
            end
            ST_AREF: begin
                cmd  = aref_cmd;
                addr = aref_addr;
            end
            ST_WRITE: begin
                cmd  = wr_cmd;
                addr = wr_addr;
                bank = wr_bank;
            end
            ST_READ: begin
                cmd  = rd_cmd;
                addr = rd_addr;
                bank = rd_bank;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: gates traffic until init completes, then grants refresh > write > read.
// Latency: grant pulse one edge after the request is seen; masters hold req until their *_en, end via flag_*_end.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int MAX_BUSY = MAX_BUSY_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              flag_init_end,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    output logic              ref_en,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_bank,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_bank,
    output logic              rd_en,
    output logic              ref_pending,
    output logic              arb_err,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [1:0]        sdram_bank
);

    localparam int              CNT_W   = (MAX_BUSY > 2) ? $clog2(MAX_BUSY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BUSY - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] busy_cnt, busy_cnt_nxt;
    logic             ref_en_nxt, wr_en_nxt, rd_en_nxt, arb_err_nxt;
    logic             owner_end;
    logic [3:0]       pin_cmd;

    always_comb begin
        owner_end = 1'b0;
        case (state)
            ST_AREF:  owner_end = flag_ref_end;
            ST_WRITE: owner_end = flag_wr_end;
            ST_READ:  owner_end = flag_rd_end;
            default:  owner_end = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        ref_en_nxt   = 1'b0;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        arb_err_nxt  = 1'b0;
        case (state)
            ST_INIT: begin
                if (flag_init_end)
                    state_nxt = ST_ARBIT;
            end
            ST_ARBIT: begin
                busy_cnt_nxt = '0;
                if (ref_req) begin
                    state_nxt  = ST_AREF;
                    ref_en_nxt = 1'b1;
                end else if (wr_req) begin
                    state_nxt = ST_WRITE;
                    wr_en_nxt = 1'b1;
                end else if (rd_req) begin
                    state_nxt = ST_READ;
                    rd_en_nxt = 1'b1;
                end
            end
            ST_AREF, ST_WRITE, ST_READ: begin
                // A normal end on the limit cycle takes precedence over the abort.
                if (owner_end) begin
                    state_nxt = ST_ARBIT;
                end else if (busy_cnt == CNT_MAX) begin
                    state_nxt   = ST_ARBIT;
                    arb_err_nxt = 1'b1;
                end else begin
                    busy_cnt_nxt = busy_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            busy_cnt    <= '0;
            ref_en      <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            arb_err     <= 1'b0;
            ref_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_cnt    <= busy_cnt_nxt;
            ref_en      <= ref_en_nxt;
            wr_en       <= wr_en_nxt;
            rd_en       <= rd_en_nxt;
            arb_err     <= arb_err_nxt;
            ref_pending <= ref_req && ((state == ST_WRITE) || (state == ST_READ));
        end
    end

    sdram_cmd_mux #(
        .ADDR_W(ADDR_W)
    ) u_cmd_mux (
        .state     (state),
        .init_cmd  (init_cmd),
        .init_addr (init_addr),
        .aref_cmd  (aref_cmd),
        .aref_addr (aref_addr),
        .wr_cmd    (wr_cmd),
        .wr_addr   (wr_addr),
        .wr_bank   (wr_bank),
        .rd_cmd    (rd_cmd),
        .rd_addr   (rd_addr),
        .rd_bank   (rd_bank),
        .cmd       (pin_cmd),
        .addr      (sdram_addr),
        .bank      (sdram_bank)
    );

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init gating, priority, pin mux, refresh-pending, watchdog, async reset.
module tb_sdram_arbit;
    import sdram_pkg::*;

    logic        sclk = 1'b0;
    logic        reset;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic        flag_init_end, ref_req, flag_ref_end, wr_req, flag_wr_end, rd_req, flag_rd_end;
    logic        ref_en, wr_en, rd_en, ref_pending, arb_err;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;

    int checks = 0;
    int errors = 0;

    sdram_arbit #(.MAX_BUSY(64), .ADDR_W(13)) dut (
        .sclk(sclk), .reset(reset),
        .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
        .ref_req(ref_req), .flag_ref_end(flag_ref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .ref_en(ref_en),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .wr_bank(wr_bank), .wr_en(wr_en),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .rd_bank(rd_bank), .rd_en(rd_en),
        .ref_pending(ref_pending), .arb_err(arb_err), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
    );

    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pins();
        return {13'd0, sdram_bank, sdram_addr, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    endfunction

    function automatic logic [31:0] pv(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b);
        return {13'd0, b, a, c};
    endfunction

    function automatic logic [31:0] grants();
        return {29'd0, ref_en, wr_en, rd_en};
    endfunction

    initial begin
        int en_seen;
        int pin_bad;
        reset = 1'b0;
        init_cmd = CMD_PRE;   init_addr = 13'h0400;
        aref_cmd = CMD_AREF;  aref_addr = 13'h00AA;
        wr_cmd = 4'b0100;     wr_addr = 13'h0155; wr_bank = 2'd2;
        rd_cmd = CMD_RD;      rd_addr = 13'h00F0; rd_bank = 2'd1;
        flag_init_end = 1'b0; ref_req = 1'b0; flag_ref_end = 1'b0;
        wr_req = 1'b0; flag_wr_end = 1'b0; rd_req = 1'b0; flag_rd_end = 1'b0;

        // Reset state
        ticks(2);
        chk("rst_grants", grants(), 32'd0);
        chk("rst_err_pend", {30'd0, arb_err, ref_pending}, 32'd0);
        chk("rst_pins", pins(), pv(CMD_PRE, 13'h0400, 2'd0));
        chk("rst_cke", {31'd0, sdram_cke}, 32'd1);

        // Init gating with a refresh request waiting
        reset = 1'b1;
        ref_req = 1'b1;
        en_seen = 0;
        pin_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ref_en || wr_en || rd_en) en_seen++;
            if (pins() !== pv(CMD_PRE, 13'h0400, 2'd0)) pin_bad++;
        end
        chk("init_no_grant", en_seen, 0);
        chk("init_pins_held", pin_bad, 0);
        flag_init_end = 1'b1;
        tick();
        chk("init_to_arbit_pins", pins(), pv(CMD_NOP, 13'h0, 2'd0));
        chk("init_to_arbit_noen", grants(), 32'd0);
        tick();
        chk("first_ref_en", grants(), 32'b100);
        chk("aref_pins", pins(), pv(CMD_AREF, 13'h00AA, 2'd0));
        ref_req = 1'b0;
        tick();
        chk("ref_en_1cyc", grants(), 32'd0);
        flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        chk("ref_end_arbit", pins(), pv(CMD_NOP, 13'h0, 2'd0));

        // Priority: all three requesting
        ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk("prio_ref", grants(), 32'b100);
        ref_req = 1'b0;
        tick();
        chk("prio_ref_pulse", grants(), 32'd0);
        flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        chk("prio_gap1_pins", pins(), pv(CMD_NOP, 13'h0, 2'd0));
        chk("prio_gap1_noen", grants(), 32'd0);
        tick();
        chk("prio_wr", grants(), 32'b010);
        chk("mux_write", pins(), pv(4'b0100, 13'h0155, 2'd2));
        chk("mux_write_csn", {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, 32'b0100);
        wr_req = 1'b0;
        tick();
        chk("prio_wr_pulse", grants(), 32'd0);
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        chk("prio_gap2_pins", pins(), pv(CMD_NOP, 13'h0, 2'd0));
        chk("prio_gap2_noen", grants(), 32'd0);
        tick();
        chk("prio_rd", grants(), 32'b001);
        chk("mux_read", pins(), pv(CMD_RD, 13'h00F0, 2'd1));
        rd_req = 1'b0;

        // Refresh requested during a read burst
        ticks(5);
        chk("rd_no_pending", {31'd0, ref_pending}, 32'd0);
        chk("rd_en_dropped", grants(), 32'd0);
        ref_req = 1'b1; wr_req = 1'b1;
        #1;
        chk("pending_lags", {31'd0, ref_pending}, 32'd0);
        tick();
        chk("pending_set", {31'd0, ref_pending}, 32'd1);
        chk("rd_holds_bus", pins(), pv(CMD_RD, 13'h00F0, 2'd1));
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        chk("rd_end_arbit", pins(), pv(CMD_NOP, 13'h0, 2'd0));
        tick();
        chk("ref_beats_wr", grants(), 32'b100);
        chk("pending_clear", {31'd0, ref_pending}, 32'd0);
        ref_req = 1'b0;
        flag_ref_end = 1'b1;
        tick();
        flag_ref_end = 1'b0;
        tick();
        chk("wr_after_ref", grants(), 32'b010);
        wr_req = 1'b0;

        // Watchdog abort: no end flag for 64 cycles
        ticks(63);
        chk("wd_still_write", pins(), pv(4'b0100, 13'h0155, 2'd2));
        chk("wd_no_err_yet", {31'd0, arb_err}, 32'd0);
        tick();
        chk("wd_abort_arbit", pins(), pv(CMD_NOP, 13'h0, 2'd0));
        chk("wd_err_pulse", {31'd0, arb_err}, 32'd1);
        tick();
        chk("wd_err_1cyc", {31'd0, arb_err}, 32'd0);

        // End flag on the limit cycle wins
        wr_req = 1'b1;
        tick();
        chk("wd2_wr_en", grants(), 32'b010);
        wr_req = 1'b0;
        ticks(63);
        chk("wd2_still_write", pins(), pv(4'b0100, 13'h0155, 2'd2));
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        chk("wd2_arbit", pins(), pv(CMD_NOP, 13'h0, 2'd0));
        chk("wd2_no_err", {31'd0, arb_err}, 32'd0);
        tick();
        chk("wd2_no_err_late", {31'd0, arb_err}, 32'd0);

        // Async reset mid-write
        wr_req = 1'b1;
        tick();
        chk("rst_mid_wr_en", grants(), 32'b010);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_grants", grants(), 32'd0);
        chk("rst_mid_pins", pins(), pv(CMD_PRE, 13'h0400, 2'd0));
        wr_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("reinit_arbit", pins(), pv(CMD_NOP, 13'h0, 2'd0));
        flag_init_end = 1'b0;
        ticks(3);
        chk("init_fall_ignored", pins(), pv(CMD_NOP, 13'h0, 2'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
